// File: rtl/sample_pacer_pkg.sv
// Shared types and default widths for the sample pacer and its edge divider.
package sample_pacer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam int unsigned DATA_W_DEFAULT  = 16;
    localparam int unsigned DIV_W_DEFAULT   = 8;
    localparam int unsigned CNT_W_DEFAULT   = 16;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/sample_pacer_rise_divider.sv
// rise_divider: rising-edge detect on a synchronized level, divided by (div+1)
// into single-cycle ticks. Reusable by any sample-rate consumer.
module rise_divider
    import sample_pacer_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pulse_sync,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic             prev;
    logic             primed;
    logic [DIV_W-1:0] cnt;
    logic             rise;
    logic             wrap;

    // primed masks the first cycle after reset so a level already high at
    // release is not mistaken for a fresh edge.
    assign rise = pulse_sync & ~prev & primed;
    assign wrap = (cnt >= div);
    assign tick = enable & rise & wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev   <= 1'b0;
            primed <= 1'b0;
            cnt    <= '0;
        end else begin
            prev   <= pulse_sync;
            primed <= 1'b1;
            if (!enable) begin
                cnt <= '0;
            end else if (rise) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sample_pacer.sv
// sample_pacer: divides sample-clock edges into ticks and fetches one sample per
// tick over a req/ack handshake. Optional REQ timeout: SAMPLE_PACER_TIMEOUT_EN.
module sample_pacer
    import sample_pacer_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned DIV_W   = DIV_W_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
`ifdef SAMPLE_PACER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pulse_sync,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div,
    output logic              req,
    input  logic              ack,
    input  logic [DATA_W-1:0] sample_in,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              overrun,
    input  logic              clr_overrun,
    output logic [CNT_W-1:0]  tick_count
`ifdef SAMPLE_PACER_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    state_t state;
    state_t state_next;
    logic   tick;
    logic   capture;
    logic   drop;
    logic   expire;

    rise_divider #(
        .DIV_W(DIV_W)
    ) u_rise_divider (
        .clk       (clk),
        .reset_n   (reset_n),
        .pulse_sync(pulse_sync),
        .enable    (enable),
        .div       (div),
        .tick      (tick)
    );

    assign req = (state == REQ);

`ifdef SAMPLE_PACER_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_done;

    assign wait_done = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    // Counter idles at 0 and is cleared on every capture, so each fetch
    // (including tick+ack re-entry) starts a fresh wait window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != REQ || capture || expire) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (expire) begin
                timeout_err <= 1'b1;
            end else if (clr_overrun) begin
                timeout_err <= 1'b0;
            end
        end
    end
`endif

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        drop       = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    capture    = 1'b1;
                    state_next = tick ? REQ : IDLE;
                end else begin
                    drop = tick;
`ifdef SAMPLE_PACER_TIMEOUT_EN
                    if (wait_done) begin
                        expire     = 1'b1;
                        state_next = IDLE;
                    end
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            tick_count   <= '0;
        end else begin
            state        <= state_next;
            sample_valid <= capture;
            if (capture) begin
                sample_out <= sample_in;
            end
            if (tick) begin
                tick_count <= tick_count + 1'b1;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
